delay_line_var: RTL and testbench
=================================

# delay_line_var

Parametrised, runtime-selectable signed sample delay line for the datapath pipeline. It replaces the fixed-length delay blocks used to align parallel datapath branches. It provides:
- configurable width and maximum depth;
- a per-cycle delay select;
- a stall (enable) input;
- a per-sample valid flag;
- a synchronous flush.

A sample entered with the delay select at 7 and enable held high appears at the output exactly 7 clocks later, the same as the existing fixed 7-cycle alignment delay.

## Interface
- WIDTH, 25, sample width in bits (signed two's complement).
- MAX_DELAY, 16, number of storage stages and largest selectable delay. Legal range is 2..64.
- SELW, $clog2(MAX_DELAY+1), width of delay_sel (derived; not overridden).

- clk  in  1  rising-edge clock; the only clock.
- reset  in  1  synchronous, active-high reset.
- en  in  1  advance enable; 0 holds every stage (stall).
- flush  in  1  synchronous clear of all stored samples.
- delay_sel  in  SELW  requested delay in clocks, unsigned.
- data_in  in  WIDTH  signed input sample.
- valid_in  in  1  qualifies data_in.
- data_out  out  WIDTH  signed delayed sample.
- valid_out  out  1  qualifies data_out.

## Operation
- Storage:
  - MAX_DELAY stages, stage[0]..stage[MAX_DELAY-1].
  - Each stage holds a WIDTH-bit data register plus a 1-bit valid register.
- Effective delay d = delay_sel clamped to the range 1..MAX_DELAY:
  - delay_sel = 0 acts as d = 1;
  - delay_sel > MAX_DELAY acts as d = MAX_DELAY.
- Priority at each rising clk edge: reset, then flush, then en.
- Reset:
  - every stage data is 0 and every stage valid is 0;
  - therefore data_out = 0 and valid_out = 0 from the first edge with reset high.
- Flush (reset low):
  - same clearing as reset;
  - data_in and valid_in on that cycle are discarded;
  - en is ignored.
- en = 1 (reset and flush low):
  - stage[0] <= {data_in, valid_in};
  - stage[i] <= stage[i-1] for i = 1..MAX_DELAY-1.
- en = 0: all stages hold their values, including valid bits.
- Output tap: data_out = stage[d-1].data and valid_out = stage[d-1].valid.
  - The tap is a mux driven by delay_sel over registered stages.
  - No combinational path from data_in or valid_in to any output.
- When valid_out = 0, data_out still shows the stage content; it is not forced to 0.
- Data is passed bit-exact: no arithmetic, rounding or sign manipulation. Signedness is preserved because only whole words are moved.
- Changing delay_sel:
  - the tap switches in the same cycle;
  - stored samples are unaffected;
  - samples may repeat (d increased) or be skipped (d decreased).
  - Downstream owns delay changes; the block applies no guard.

## Timing
- Latency: a sample captured at enabled edge k appears on data_out/valid_out after the d-th enabled edge counting from k.
  - With en held high this is exactly d clocks.
  - Stalled cycles add 1:1 to the latency.
- Output changes only on clk edges while delay_sel is constant.
- Output change on a delay_sel change is combinational (mux only), within the same cycle.
- After reset or flush deasserts, valid_out is 0 for at least d enabled edges. No stale sample ever emerges.
- Flush and en in the same cycle: flush wins and the pipeline is empty afterwards.
- Reset asserted mid-stream: all in-flight samples are lost, and the outputs read 0 / 0 after that edge.
- Throughput: one sample per enabled clock. There is no backpressure output.

## Test plan
- Reset values: assert reset 2 cycles while data_in = 25'h0AAAAAA and valid_in = 1 -> data_out = 0 and valid_out = 0 during reset and for the following 7 clocks with delay_sel = 7.
- Fixed-delay equivalence:
  - stimulus: delay_sel = 7, en = 1, ramp data_in = -3, -2, ..., 20 with valid_in = 1;
  - required: each value appears on data_out exactly 7 clocks later with valid_out = 1, including negative values sign-correct.
- Stall:
  - stimulus: delay_sel = 4, send 10, 11, 12, 13 on consecutive cycles, then en = 0 for 3 cycles;
  - required: data_out freezes at its current value for those 3 cycles;
  - 10 emerges 4 enabled edges after capture, i.e. 7 clocks when the stall falls inside its path.
- Delay change:
  - stimulus: stream 0..31 at d = 8, then switch delay_sel to 3;
  - required: data_out jumps forward 5 samples in the same cycle, with no X and valid_out still 1;
  - stimulus: switch back to 8;
  - required: 5 samples repeat.
- Flush:
  - stimulus: fill at d = 5 with values 100..104, assert flush for 1 cycle with en = 1 and valid_in = 1 (data 999);
  - required: valid_out = 0 for the next 5 clocks, and 999 never appears.
- Clamp:
  - stimulus: delay_sel = 0;
  - required: 1-clock delay;
  - stimulus: delay_sel = MAX_DELAY+1 (and all-ones);
  - required: MAX_DELAY-clock delay with correct data.

Source files
------------

// File: rtl/delay_line_var_if.sv
// Sample/control bundle for the variable delay line.
// The master drives the sample and control inputs; the slave is the delay line itself.
interface delay_line_var_if #(
  parameter int unsigned WIDTH     = 25,
  parameter int unsigned MAX_DELAY = 16
);
  localparam int unsigned SELW = $clog2(MAX_DELAY + 1);

  logic                    en;
  logic                    flush;
  logic [SELW-1:0]         delay_sel;
  logic signed [WIDTH-1:0] data_in;
  logic                    valid_in;
  logic signed [WIDTH-1:0] data_out;
  logic                    valid_out;

  modport master (
    output en, flush, delay_sel, data_in, valid_in,
    input  data_out, valid_out
  );

  modport slave (
    input  en, flush, delay_sel, data_in, valid_in,
    output data_out, valid_out
  );
endinterface

// File: rtl/delay_line_var.sv
// Runtime-selectable signed sample delay line with stall, per-sample valid and flush.
// The output is a delay_sel-driven mux over registered stages, so delay changes take effect in the same cycle.
module delay_line_var #(
  parameter int unsigned WIDTH     = 25,
  parameter int unsigned MAX_DELAY = 16
) (
  input  logic            clk,
  input  logic            reset,
  delay_line_var_if.slave bus
);
  localparam int unsigned SELW = $clog2(MAX_DELAY + 1);
  localparam int unsigned TAPW = $clog2(MAX_DELAY);

  logic signed [WIDTH-1:0] r_data [MAX_DELAY];
  logic [MAX_DELAY-1:0]    r_valid;
  logic [TAPW-1:0]         w_tap;

  // Clamp delay_sel to 1..MAX_DELAY and convert to a stage index.
  always_comb begin
    w_tap = '0;
    if (32'(bus.delay_sel) >= MAX_DELAY) begin
      w_tap = TAPW'(MAX_DELAY - 1);
    end else if (bus.delay_sel != '0) begin
      w_tap = TAPW'(bus.delay_sel - SELW'(1));
    end
  end

  always_ff @(posedge clk) begin
    if (reset || bus.flush) begin
      r_valid <= '0;
      for (int i = 0; i < int'(MAX_DELAY); i++) begin
        r_data[i] <= '0;
      end
    end else if (bus.en) begin
      r_valid   <= {r_valid[MAX_DELAY-2:0], bus.valid_in};
      r_data[0] <= bus.data_in;
      for (int i = 1; i < int'(MAX_DELAY); i++) begin
        r_data[i] <= r_data[i-1];
      end
    end
  end

  assign bus.data_out  = r_data[w_tap];
  assign bus.valid_out = r_valid[w_tap];

endmodule

// File: tb/tb_delay_line_var.sv
// Scoreboard bench for delay_line_var: a capture history predicts each cycle's tap output.
module tb_delay_line_var;
  localparam int unsigned WIDTH     = 25;
  localparam int unsigned MAX_DELAY = 16;
  localparam int unsigned SELW      = $clog2(MAX_DELAY + 1);

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  delay_line_var_if #(.WIDTH(WIDTH), .MAX_DELAY(MAX_DELAY)) tif();

  delay_line_var #(.WIDTH(WIDTH), .MAX_DELAY(MAX_DELAY)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (tif)
  );

  int n_total = 0;
  int n_bad   = 0;

  // Every sample ever captured, oldest first; a clear appends MAX_DELAY empty entries.
  logic [WIDTH:0] hist [$];
  logic [WIDTH:0] exp_q [$];

  task automatic check_eq(input string tag, input logic [WIDTH:0] obs, input logic [WIDTH:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got data=%0d valid=%b, want data=%0d valid=%b",
               tag, $signed(obs[WIDTH:1]), obs[0], $signed(exp[WIDTH:1]), exp[0]);
    end
  endtask

  function automatic logic [WIDTH:0] model_tap(input int sel);
    int d;
    d = (sel < 1) ? 1 : ((sel > int'(MAX_DELAY)) ? int'(MAX_DELAY) : sel);
    return hist[hist.size() - d];
  endfunction

  task automatic cyc(input string tag, input logic rst, input logic fl, input logic e,
                     input int sel, input int din, input logic vin);
    logic [WIDTH:0] exp;
    reset         = rst;
    tif.flush     = fl;
    tif.en        = e;
    tif.delay_sel = SELW'(sel);
    tif.data_in   = WIDTH'(din);
    tif.valid_in  = vin;
    @(posedge clk);
    if (rst || fl) begin
      repeat (MAX_DELAY) hist.push_back('0);
    end else if (e) begin
      hist.push_back({WIDTH'(din), vin});
    end
    exp_q.push_back(model_tap(sel));
    #1;
    exp = exp_q.pop_front();
    check_eq(tag, {tif.data_out, tif.valid_out}, exp);
  endtask

  // Mid-cycle delay change: the tap must follow without a clock edge.
  task automatic sel_change(input string tag, input int sel);
    logic [WIDTH:0] exp;
    tif.delay_sel = SELW'(sel);
    exp_q.push_back(model_tap(sel));
    #1;
    exp = exp_q.pop_front();
    check_eq(tag, {tif.data_out, tif.valid_out}, exp);
  endtask

  initial begin
    reset         = 1'b0;
    tif.flush     = 1'b0;
    tif.en        = 1'b0;
    tif.delay_sel = '0;
    tif.data_in   = '0;
    tif.valid_in  = 1'b0;
    #2;

    repeat (2) cyc("reset", 1'b1, 1'b0, 1'b1, 7, 25'h0AAAAAA, 1'b1);
    check_eq("reset_zero", {tif.data_out, tif.valid_out}, '0);
    repeat (7) cyc("post_reset", 1'b0, 1'b0, 1'b1, 7, 0, 1'b0);

    for (int v = -3; v <= 20; v++) cyc("ramp_d7", 1'b0, 1'b0, 1'b1, 7, v, 1'b1);
    check_eq("ramp_neg", {tif.data_out, tif.valid_out}, {WIDTH'(-3 + 17), 1'b1});
    repeat (7) cyc("ramp_drain", 1'b0, 1'b0, 1'b1, 7, 0, 1'b0);

    for (int v = 10; v <= 13; v++) cyc("stall_fill", 1'b0, 1'b0, 1'b1, 4, v, 1'b1);
    repeat (3) cyc("stall_hold", 1'b0, 1'b0, 1'b0, 4, 0, 1'b0);
    repeat (5) cyc("stall_drain", 1'b0, 1'b0, 1'b1, 4, 0, 1'b0);
    // Stall inside the path of a sample: latency stretches by the stall length.
    cyc("stall2_in", 1'b0, 1'b0, 1'b1, 4, 50, 1'b1);
    repeat (3) cyc("stall2_hold", 1'b0, 1'b0, 1'b0, 4, 0, 1'b0);
    repeat (5) cyc("stall2_out", 1'b0, 1'b0, 1'b1, 4, 0, 1'b0);

    for (int v = 0; v <= 31; v++) cyc("dchg_d8", 1'b0, 1'b0, 1'b1, 8, v, 1'b1);
    sel_change("dchg_to3", 3);
    check_eq("dchg_jump", {tif.data_out, tif.valid_out}, {WIDTH'(29), 1'b1});
    for (int v = 32; v <= 39; v++) cyc("dchg_d3", 1'b0, 1'b0, 1'b1, 3, v, 1'b1);
    sel_change("dchg_to8", 8);
    check_eq("dchg_repeat", {tif.data_out, tif.valid_out}, {WIDTH'(32), 1'b1});
    for (int v = 40; v <= 47; v++) cyc("dchg_back", 1'b0, 1'b0, 1'b1, 8, v, 1'b1);

    for (int v = 100; v <= 104; v++) cyc("flush_fill", 1'b0, 1'b0, 1'b1, 5, v, 1'b1);
    cyc("flush", 1'b0, 1'b1, 1'b1, 5, 999, 1'b1);
    repeat (5) begin
      cyc("flush_after", 1'b0, 1'b0, 1'b1, 5, 0, 1'b0);
      check_eq("flush_no999", (WIDTH+1)'(tif.data_out == WIDTH'(999)), '0);
    end

    for (int i = 0; i < 8; i++) cyc("clamp_0", 1'b0, 1'b0, 1'b1, 0, 200 + i, 1'b1);
    check_eq("clamp_0_d1", {tif.data_out, tif.valid_out}, {WIDTH'(207), 1'b1});
    for (int i = 0; i < 20; i++) cyc("clamp_max1", 1'b0, 1'b0, 1'b1, int'(MAX_DELAY) + 1, -300 - i, 1'b1);
    for (int i = 0; i < 20; i++) cyc("clamp_ones", 1'b0, 1'b0, 1'b1, (1 << SELW) - 1, 400 + i, 1'b1);
    check_eq("clamp_ones_d16", {tif.data_out, tif.valid_out}, {WIDTH'(404), 1'b1});

    for (int i = 0; i < 4; i++) cyc("midrst_fill", 1'b0, 1'b0, 1'b1, 2, 600 + i, 1'b1);
    cyc("midrst", 1'b1, 1'b0, 1'b1, 2, 777, 1'b1);
    repeat (3) cyc("midrst_after", 1'b0, 1'b0, 1'b1, 2, 800, 1'b1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
